// File: rtl/shot_controller_if.sv
// -----------------------------------------------------------------------------
// shot_controller_if
// Groups the sample/strobe/control and status signals of shot_controller.
// Signal names keep the controller's original port names so existing
// connections map one-to-one.
//   tick_i     decimated-rate strobe, 1 clk wide
//   signal_i   signed phase sample, valid on tick_i
//   trigger_i  shot request (level, rising edge acts)
//   play_i     replay request (level, rising edge acts)
//   abort_i    return to IDLE (level)
//   signal_o   signed replay sample
//   valid_o    1-clk strobe, signal_o updated
//   done_o     1-clk pulse at capture completion
//   busy_o     high in HOLDOFF, CAPTURE, READOUT
//   state_o    state code
//   count_o    samples written in current/last shot
// Modports: slave = controller side, master = driver side.
// -----------------------------------------------------------------------------
interface shot_controller_if #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned AW    = 10
);
   logic                    tick_i;
   logic signed [WIDTH-1:0] signal_i;
   logic                    trigger_i;
   logic                    play_i;
   logic                    abort_i;
   logic signed [WIDTH-1:0] signal_o;
   logic                    valid_o;
   logic                    done_o;
   logic                    busy_o;
   logic [2:0]              state_o;
   logic [AW:0]             count_o;

   modport slave (
      input  tick_i, signal_i, trigger_i, play_i, abort_i,
      output signal_o, valid_o, done_o, busy_o, state_o, count_o
   );

   modport master (
      output tick_i, signal_i, trigger_i, play_i, abort_i,
      input  signal_o, valid_o, done_o, busy_o, state_o, count_o
   );
endinterface

// File: rtl/shot_controller.sv
// -----------------------------------------------------------------------------
// shot_controller
// Single-shot capture sequencer for the decimated phase stream. A trigger
// rising edge skips HOLDOFF ticks, records DEPTH consecutive samples into
// internal RAM and holds them; a play rising edge replays the shot one sample
// per tick (RAM read latency 1).
// Ports:
//   clk_i   system clock
//   rst_i   synchronous reset, active-high
//   bus     shot_controller_if.slave (tick/sample/control in, replay/status out)
// Configuration macro:
//   SHOT_LOOP_EN  defined: READOUT wraps and replays continuously, leaving
//                 only on abort or a trigger rising edge (which restarts a shot).
//                 undefined: single replay pass, then back to READY.
// State codes: IDLE=0, HOLDOFF=1, CAPTURE=2, READY=3, READOUT=4.
// -----------------------------------------------------------------------------
module shot_controller #(
   parameter int unsigned DEPTH   = 1024,
   parameter int unsigned AW      = 10,
   parameter int unsigned WIDTH   = 16,
   parameter int unsigned HOLDOFF = 16
) (
   input  logic              clk_i,
   input  logic              rst_i,
   shot_controller_if.slave  bus
);

   localparam int unsigned HCW      = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
   localparam logic [HCW-1:0] HO_LAST = HCW'(HOLDOFF - 1);
   localparam logic [AW:0]    CNT_FULL = (AW+1)'(DEPTH);
   localparam logic [AW:0]    CNT_LAST = (AW+1)'(DEPTH - 1);
   localparam logic [AW-1:0]  PTR_LAST = AW'(DEPTH - 1);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_HOLDOFF = 3'd1,
      S_CAPTURE = 3'd2,
      S_READY   = 3'd3,
      S_READOUT = 3'd4
   } state_t;

   state_t                  r_state;
   logic                    r_trig_q;
   logic                    r_play_q;
   logic [HCW-1:0]          r_hcnt;
   logic [AW-1:0]           r_wr_ptr;
   logic [AW-1:0]           r_rd_ptr;
   logic [AW:0]             r_count;
   logic signed [WIDTH-1:0] r_signal;
   logic                    r_valid;
   logic                    r_done;
   logic                    r_busy;
   logic signed [WIDTH-1:0] r_mem [DEPTH];

   logic w_trig_rise;
   logic w_play_rise;
   logic w_trig_ok;
   logic w_shot_start;
   logic w_mem_we;

   assign w_trig_rise = bus.trigger_i & ~r_trig_q;
   assign w_play_rise = bus.play_i & ~r_play_q;

   // States in which a trigger edge (re)starts a shot; elsewhere it is dropped.
`ifdef SHOT_LOOP_EN
   assign w_trig_ok = (r_state == S_IDLE) | (r_state == S_READY) | (r_state == S_READOUT);
`else
   assign w_trig_ok = (r_state == S_IDLE) | (r_state == S_READY);
`endif

   assign w_shot_start = w_trig_rise & w_trig_ok;

   // Only reset and abort outrank a capture tick; trigger/play are not accepted in CAPTURE.
   assign w_mem_we = (r_state == S_CAPTURE) & bus.tick_i & ~bus.abort_i & ~rst_i;

   // Sample buffer, no reset.
   always_ff @(posedge clk_i) begin
      if (w_mem_we) begin
         r_mem[r_wr_ptr] <= bus.signal_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state  <= S_IDLE;
         r_trig_q <= 1'b0;
         r_play_q <= 1'b0;
         r_hcnt   <= '0;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_signal <= '0;
         r_valid  <= 1'b0;
         r_done   <= 1'b0;
         r_busy   <= 1'b0;
      end else begin
         r_trig_q <= bus.trigger_i;
         r_play_q <= bus.play_i;
         r_valid  <= 1'b0;
         r_done   <= 1'b0;

         if (bus.abort_i) begin
            // count_o and buffer kept; IDLE never accepts play, so the buffer is unreachable.
            r_state  <= S_IDLE;
            r_signal <= '0;
            r_busy   <= 1'b0;
         end else if (w_shot_start) begin
            r_state  <= (HOLDOFF > 0) ? S_HOLDOFF : S_CAPTURE;
            r_count  <= '0;
            r_wr_ptr <= '0;
            r_hcnt   <= '0;
            r_signal <= '0;
            r_busy   <= 1'b1;
         end else begin
            case (r_state)
               S_IDLE: begin
                  r_signal <= '0;
               end

               S_HOLDOFF: begin
                  if (bus.tick_i) begin
                     if (r_hcnt == HO_LAST) begin
                        r_state <= S_CAPTURE;
                     end else begin
                        r_hcnt <= r_hcnt + HCW'(1);
                     end
                  end
               end

               S_CAPTURE: begin
                  if (bus.tick_i) begin
                     r_wr_ptr <= r_wr_ptr + AW'(1);
                     if (r_count != CNT_FULL) begin
                        r_count <= r_count + (AW+1)'(1);
                     end
                     if (r_count == CNT_LAST) begin
                        r_state <= S_READY;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                     end
                  end
               end

               S_READY: begin
                  // Clears the last replayed sample one clk after leaving READOUT.
                  r_signal <= '0;
                  if (w_play_rise) begin
                     r_state  <= S_READOUT;
                     r_rd_ptr <= '0;
                     r_busy   <= 1'b1;
                  end
               end

               S_READOUT: begin
                  if (bus.tick_i) begin
                     r_signal <= r_mem[r_rd_ptr];
                     r_valid  <= 1'b1;
                     r_rd_ptr <= r_rd_ptr + AW'(1);
`ifndef SHOT_LOOP_EN
                     if (r_rd_ptr == PTR_LAST) begin
                        r_state <= S_READY;
                        r_busy  <= 1'b0;
                     end
`endif
                  end
               end

               default: begin
                  r_state  <= S_IDLE;
                  r_signal <= '0;
                  r_busy   <= 1'b0;
               end
            endcase
         end
      end
   end

   assign bus.signal_o = r_signal;
   assign bus.valid_o  = r_valid;
   assign bus.done_o   = r_done;
   assign bus.busy_o   = r_busy;
   assign bus.state_o  = r_state;
   assign bus.count_o  = r_count;

endmodule

// File: tb/tb_shot_controller.sv
// -----------------------------------------------------------------------------
// tb_shot_controller
// Bench for shot_controller with DEPTH=8, HOLDOFF=2, tick every 5 clk and
// random sample values. Expected buffers and replay sequences are derived
// from tick numbering relative to trigger/play edges.
// Honours SHOT_LOOP_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_shot_controller;
   localparam int unsigned DEPTH   = 8;
   localparam int unsigned AW      = 3;
   localparam int unsigned WIDTH   = 16;
   localparam int unsigned HOLDOFF = 2;

   logic clk_i;
   logic rst_i;

   shot_controller_if #(.WIDTH(WIDTH), .AW(AW)) sif ();

   shot_controller #(
      .DEPTH   (DEPTH),
      .AW      (AW),
      .WIDTH   (WIDTH),
      .HOLDOFF (HOLDOFF)
   ) dut (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .bus   (sif.slave)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;
   int unsigned phase;
   logic signed [WIDTH-1:0] tick_val;
   logic signed [WIDTH-1:0] exp_buf [DEPTH];
   bit last_tick;

   // One clock: drive inputs, take the edge, sample 1 ns after it.
   task automatic cycle();
      sif.signal_i = WIDTH'($urandom);
      if (phase == 4) begin
         phase = 0;
         sif.tick_i = 1'b1;
         tick_val = sif.signal_i;
      end else begin
         phase++;
         sif.tick_i = 1'b0;
      end
      last_tick = sif.tick_i;
      @(posedge clk_i);
      #1;
   endtask

   task automatic test_reset();
      int unsigned cyc = 0;
      rst_i = 1'b1;
      repeat (3) cycle();
      n_cmp++; if (sif.state_o !== 3'd0) begin n_bad++; $display("FAIL rst_state: got %0d expected 0", sif.state_o); end
      n_cmp++; if (sif.count_o !== '0) begin n_bad++; $display("FAIL rst_count: got %0d expected 0", sif.count_o); end
      n_cmp++; if ({sif.valid_o, sif.done_o, sif.busy_o} !== 3'b000) begin n_bad++; $display("FAIL rst_flags: got %b expected 000", {sif.valid_o, sif.done_o, sif.busy_o}); end
      rst_i = 1'b0;
      sif.trigger_i = 1'b1;
      cycle();
      sif.trigger_i = 1'b0;
      while (sif.count_o != 3 && cyc < 300) begin cycle(); cyc++; end
      n_cmp++; if (cyc >= 300) begin n_bad++; $display("FAIL rst_reach_count3: got timeout expected count 3"); end
      rst_i = 1'b1;
      cycle();
      rst_i = 1'b0;
      n_cmp++; if (sif.state_o !== 3'd0) begin n_bad++; $display("FAIL midrst_state: got %0d expected 0", sif.state_o); end
      n_cmp++; if (sif.count_o !== '0) begin n_bad++; $display("FAIL midrst_count: got %0d expected 0", sif.count_o); end
      n_cmp++; if ({sif.valid_o, sif.done_o, sif.busy_o} !== 3'b000 || sif.signal_o !== '0) begin n_bad++; $display("FAIL midrst_outputs: got v/d/b=%b sig=%0d expected 000 and 0", {sif.valid_o, sif.done_o, sif.busy_o}, sif.signal_o); end
      cycle();
      n_cmp++; if (sif.state_o !== 3'd0) begin n_bad++; $display("FAIL midrst_stay_idle: got %0d expected 0", sif.state_o); end
   endtask

   // held=1: trigger stays high through the shot and play pulses mid-capture.
   task automatic test_capture(input bit held);
      int unsigned k = 0, cyc = 0, dones = 0, exp_cnt, exp_state;
      bit played = 1'b0;
      sif.trigger_i = 1'b0; sif.play_i = 1'b0; sif.abort_i = 1'b0;
      cycle();
      sif.trigger_i = 1'b1;
      cycle();
      if (!held) sif.trigger_i = 1'b0;
      exp_state = (HOLDOFF > 0) ? 1 : 2;
      n_cmp++; if (sif.state_o !== 3'(exp_state)) begin n_bad++; $display("FAIL cap_start_state: got %0d expected %0d", sif.state_o, exp_state); end
      n_cmp++; if (sif.count_o !== '0 || sif.busy_o !== 1'b1) begin n_bad++; $display("FAIL cap_start_cnt_busy: got cnt=%0d busy=%b expected 0 1", sif.count_o, sif.busy_o); end
      while (k < HOLDOFF + DEPTH + 2 && cyc < 400) begin
         sif.play_i = held && !played && k == HOLDOFF + 4;
         if (sif.play_i) played = 1'b1;
         cycle();
         cyc++;
         if (last_tick) begin
            k++;
            if (k > HOLDOFF && k <= HOLDOFF + DEPTH) exp_buf[k-HOLDOFF-1] = tick_val;
         end
         if (sif.done_o === 1'b1) begin
            dones++;
            n_cmp++; if (!(last_tick && k == HOLDOFF + DEPTH)) begin n_bad++; $display("FAIL cap_done_time: got done at tick %0d expected tick %0d", k, HOLDOFF + DEPTH); end
         end
         exp_cnt = (k <= HOLDOFF) ? 0 : ((k - HOLDOFF > DEPTH) ? DEPTH : k - HOLDOFF);
         exp_state = (k < HOLDOFF) ? 1 : ((k < HOLDOFF + DEPTH) ? 2 : 3);
         n_cmp++; if (sif.count_o !== (AW+1)'(exp_cnt)) begin n_bad++; $display("FAIL cap_count: got %0d expected %0d", sif.count_o, exp_cnt); end
         n_cmp++; if (sif.state_o !== 3'(exp_state)) begin n_bad++; $display("FAIL cap_state: got %0d expected %0d", sif.state_o, exp_state); end
         n_cmp++; if (sif.busy_o !== (exp_state != 3)) begin n_bad++; $display("FAIL cap_busy: got %b expected %b", sif.busy_o, exp_state != 3); end
      end
      sif.play_i = 1'b0;
      n_cmp++; if (cyc >= 400) begin n_bad++; $display("FAIL cap_timeout: got %0d ticks expected %0d", k, HOLDOFF + DEPTH + 2); end
      n_cmp++; if (dones != 1) begin n_bad++; $display("FAIL cap_done_pulses: got %0d expected 1", dones); end
   endtask

   task automatic test_readout();
      int unsigned j = 0, cyc = 0, n_ticks, exp_state;
`ifdef SHOT_LOOP_EN
      n_ticks = 3 * DEPTH;
`else
      n_ticks = DEPTH;
`endif
      sif.trigger_i = 1'b0; sif.play_i = 1'b0; sif.abort_i = 1'b0;
      cycle();
      sif.play_i = 1'b1;
      cycle();
      if ($urandom_range(0, 1) == 0) sif.play_i = 1'b0;
      n_cmp++; if (sif.state_o !== 3'd4 || sif.busy_o !== 1'b1 || sif.valid_o !== 1'b0) begin n_bad++; $display("FAIL rd_start: got st=%0d busy=%b valid=%b expected 4 1 0", sif.state_o, sif.busy_o, sif.valid_o); end
      while (j < n_ticks && cyc < 1000) begin
         cycle();
         cyc++;
         if (last_tick) begin
            j++;
`ifdef SHOT_LOOP_EN
            exp_state = 4;
`else
            exp_state = (j < DEPTH) ? 4 : 3;
`endif
            n_cmp++; if (sif.valid_o !== 1'b1) begin n_bad++; $display("FAIL rd_valid: got %b expected 1 at sample %0d", sif.valid_o, j); end
            n_cmp++; if (sif.signal_o !== exp_buf[(j-1) % DEPTH]) begin n_bad++; $display("FAIL rd_sample: got %0d expected %0d at sample %0d", sif.signal_o, exp_buf[(j-1) % DEPTH], j); end
            n_cmp++; if (sif.state_o !== 3'(exp_state)) begin n_bad++; $display("FAIL rd_state: got %0d expected %0d", sif.state_o, exp_state); end
         end else begin
            n_cmp++; if (sif.valid_o !== 1'b0 || sif.state_o !== 3'd4) begin n_bad++; $display("FAIL rd_idle_cycle: got valid=%b st=%0d expected 0 4", sif.valid_o, sif.state_o); end
         end
      end
      sif.play_i = 1'b0;
      n_cmp++; if (cyc >= 1000) begin n_bad++; $display("FAIL rd_timeout: got %0d samples expected %0d", j, n_ticks); end
      cycle();
`ifdef SHOT_LOOP_EN
      n_cmp++; if (sif.state_o !== 3'd4 || sif.valid_o !== 1'b0) begin n_bad++; $display("FAIL rd_loop_stay: got st=%0d valid=%b expected 4 0", sif.state_o, sif.valid_o); end
      sif.abort_i = 1'b1;
      cycle();
      sif.abort_i = 1'b0;
      n_cmp++; if (sif.state_o !== 3'd0 || sif.valid_o !== 1'b0 || sif.signal_o !== '0 || sif.busy_o !== 1'b0) begin n_bad++; $display("FAIL rd_loop_abort: got st=%0d valid=%b sig=%0d busy=%b expected 0 0 0 0", sif.state_o, sif.valid_o, sif.signal_o, sif.busy_o); end
`else
      n_cmp++; if (sif.state_o !== 3'd3 || sif.signal_o !== '0 || sif.valid_o !== 1'b0 || sif.busy_o !== 1'b0) begin n_bad++; $display("FAIL rd_end: got st=%0d sig=%0d valid=%b busy=%b expected 3 0 0 0", sif.state_o, sif.signal_o, sif.valid_o, sif.busy_o); end
`endif
   endtask

   task automatic test_abort();
      int unsigned j = 0, cyc = 0;
      sif.trigger_i = 1'b0; sif.play_i = 1'b0; sif.abort_i = 1'b0;
      cycle();
      sif.play_i = 1'b1;
      cycle();
      sif.play_i = 1'b0;
      while (j < 4 && cyc < 200) begin
         cycle();
         cyc++;
         if (last_tick) begin
            j++;
            n_cmp++; if (sif.valid_o !== 1'b1 || sif.signal_o !== exp_buf[j-1]) begin n_bad++; $display("FAIL ab_sample: got valid=%b sig=%0d expected 1 %0d", sif.valid_o, sif.signal_o, exp_buf[j-1]); end
         end
      end
      n_cmp++; if (cyc >= 200) begin n_bad++; $display("FAIL ab_timeout: got %0d samples expected 4", j); end
      sif.abort_i = 1'b1;
      sif.trigger_i = 1'b1;
      cycle();
      sif.abort_i = 1'b0;
      n_cmp++; if (sif.state_o !== 3'd0 || sif.valid_o !== 1'b0 || sif.signal_o !== '0 || sif.busy_o !== 1'b0) begin n_bad++; $display("FAIL ab_idle: got st=%0d valid=%b sig=%0d busy=%b expected 0 0 0 0", sif.state_o, sif.valid_o, sif.signal_o, sif.busy_o); end
      n_cmp++; if (sif.count_o !== (AW+1)'(DEPTH)) begin n_bad++; $display("FAIL ab_count_kept: got %0d expected %0d", sif.count_o, DEPTH); end
      repeat (12) begin
         cycle();
         n_cmp++; if (sif.state_o !== 3'd0 || sif.busy_o !== 1'b0) begin n_bad++; $display("FAIL ab_no_restart: got st=%0d busy=%b expected 0 0", sif.state_o, sif.busy_o); end
      end
      sif.trigger_i = 1'b0;
   endtask

   task automatic test_play_in_idle();
      sif.trigger_i = 1'b0; sif.abort_i = 1'b0;
      sif.play_i = 1'b1;
      cycle();
      sif.play_i = 1'b0;
      repeat (15) begin
         cycle();
         n_cmp++; if (sif.state_o !== 3'd0 || sif.valid_o !== 1'b0 || sif.signal_o !== '0) begin n_bad++; $display("FAIL idle_play: got st=%0d valid=%b sig=%0d expected 0 0 0", sif.state_o, sif.valid_o, sif.signal_o); end
      end
      n_cmp++; if (sif.count_o !== (AW+1)'(DEPTH)) begin n_bad++; $display("FAIL idle_count: got %0d expected %0d", sif.count_o, DEPTH); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish before 200 us");
      $fatal(1, "watchdog");
   end

   initial begin
      phase = $urandom_range(0, 4);
      last_tick = 1'b0;
      tick_val = '0;
      rst_i = 1'b1;
      sif.tick_i = 1'b0; sif.signal_i = '0;
      sif.trigger_i = 1'b0; sif.play_i = 1'b0; sif.abort_i = 1'b0;
      test_reset();
      test_capture(1'b0);
      test_readout();
      test_capture(1'b1);
      test_abort();
      test_play_in_idle();
      test_capture(1'b0);
      test_readout();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
